// File: rtl/weight_fetch_unit.sv
// Weight FIFO producer: streams weight tile rows from on-chip memory into the weight FIFO under a credit check.
// Optional backpressure stall counter is built when WFU_PERF_CNT_EN is defined.
module weight_fetch_unit #(
  parameter int MUL_SIZE = 32,
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 16,
  parameter int MEM_LAT  = 2,
  parameter int FIFO_AW  = 5
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       start_i,
  input  logic [15:0]                u_dim_i,
  input  logic [15:0]                iter_dim_i,
  input  logic [ADDR_W-1:0]          base_addr_i,
  output logic                       mem_rd_o,
  output logic [ADDR_W-1:0]          mem_addr_o,
  input  logic [MUL_SIZE*DATA_W-1:0] mem_rdata_i,
  input  logic [FIFO_AW:0]           wf_free_i,
  output logic                       wf_push_o,
  output logic [MUL_SIZE*DATA_W-1:0] wf_data_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [31:0]                stall_cycles_o
);

  localparam int ROW_W  = $clog2(MUL_SIZE);
  localparam int CNT_W  = FIFO_AW + 1;
  localparam int TILE_W = 10;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [TILE_W-1:0]   max_tiles_q, max_tiles_d;
  logic [TILE_W-1:0]   tile_q, tile_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [CNT_W-1:0]    inflight_q, inflight_d;
  logic [MEM_LAT-1:0]  vld_q, vld_d;
  logic                issue;
  logic                push;
  logic [TILE_W-1:0]   cmd_tiles;
  logic [ADDR_W-1:0]   row_offset;

  // Only the low 10 bits of the tile product are kept, same as the consumer.
  assign cmd_tiles  = TILE_W'((u_dim_i >> ROW_W) * (iter_dim_i >> ROW_W));
  assign row_offset = ADDR_W'(32'(tile_q) * 32'(MUL_SIZE) + 32'(row_q));

  // Credit: never let outstanding reads exceed the free slots the FIFO reports.
  assign issue = (state_q == S_FETCH) && (wf_free_i > inflight_q);
  assign push  = vld_q[MEM_LAT-1];

  generate
    for (genvar gi = 0; gi < MEM_LAT; gi++) begin : g_vld
      if (gi == 0) begin : g_head
        assign vld_d[gi] = issue;
      end else begin : g_tail
        assign vld_d[gi] = vld_q[gi-1];
      end
    end
  endgenerate

  always_comb begin
    inflight_d = inflight_q;
    if (issue && !push) begin
      inflight_d = inflight_q + CNT_W'(1);
    end else if (!issue && push) begin
      inflight_d = inflight_q - CNT_W'(1);
    end
  end

  always_comb begin
    state_d     = state_q;
    max_tiles_d = max_tiles_q;
    tile_d      = tile_q;
    row_d       = row_q;
    base_d      = base_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          max_tiles_d = cmd_tiles;
          base_d      = base_addr_i;
          tile_d      = '0;
          row_d       = '0;
          // An empty command passes through DRAIN so done_o lands like any other completion.
          state_d     = (cmd_tiles == '0) ? S_DRAIN : S_FETCH;
        end
      end
      S_FETCH: begin
        if (issue) begin
          if (row_q == ROW_W'(MUL_SIZE - 1)) begin
            row_d  = '0;
            tile_d = tile_q + TILE_W'(1);
            if (tile_q == max_tiles_q - TILE_W'(1)) begin
              state_d = S_DRAIN;
            end
          end else begin
            row_d = row_q + ROW_W'(1);
          end
        end
      end
      S_DRAIN: begin
        if (inflight_d == '0 && vld_d == '0) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      max_tiles_q <= '0;
      tile_q      <= '0;
      row_q       <= '0;
      base_q      <= '0;
      inflight_q  <= '0;
      vld_q       <= '0;
    end else begin
      state_q     <= state_d;
      max_tiles_q <= max_tiles_d;
      tile_q      <= tile_d;
      row_q       <= row_d;
      base_q      <= base_d;
      inflight_q  <= inflight_d;
      vld_q       <= vld_d;
    end
  end

  assign mem_rd_o   = issue;
  assign mem_addr_o = issue ? (base_q + row_offset) : '0;
  assign wf_push_o  = push;
  assign wf_data_o  = push ? mem_rdata_i : '0;
  assign busy_o     = (state_q == S_FETCH) || (state_q == S_DRAIN);
  assign done_o     = (state_q == S_DONE);

`ifdef WFU_PERF_CNT_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (state_q == S_IDLE && start_i) begin
      stall_d = '0;
    end else if (state_q == S_FETCH && !issue && stall_q != 32'hFFFF_FFFF) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cycles_o = stall_q;
`else
  assign stall_cycles_o = '0;
`endif

endmodule

// File: tb/tb_weight_fetch_unit.sv
// Randomized scoreboard bench for weight_fetch_unit: memory and FIFO are modelled here, rows checked in issue order.
module tb_weight_fetch_unit;
  localparam int MUL_SIZE = 32;
  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 16;
  localparam int MEM_LAT  = 2;
  localparam int FIFO_AW  = 5;
  localparam int RW       = MUL_SIZE * DATA_W;
  localparam int DEPTH    = 1 << FIFO_AW;

  logic              clk = 1'b0;
  logic              rst_i = 1'b1;
  logic              start_i = 1'b0;
  logic [15:0]       u_dim_i = '0;
  logic [15:0]       iter_dim_i = '0;
  logic [ADDR_W-1:0] base_addr_i = '0;
  logic              mem_rd_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [RW-1:0]     mem_rdata_i = '0;
  logic [FIFO_AW:0]  wf_free_i = '0;
  logic              wf_push_o;
  logic [RW-1:0]     wf_data_o;
  logic              busy_o;
  logic              done_o;
  logic [31:0]       stall_cycles_o;

  weight_fetch_unit #(
    .MUL_SIZE(MUL_SIZE), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_LAT(MEM_LAT), .FIFO_AW(FIFO_AW)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .u_dim_i(u_dim_i), .iter_dim_i(iter_dim_i),
    .base_addr_i(base_addr_i), .mem_rd_o(mem_rd_o), .mem_addr_o(mem_addr_o), .mem_rdata_i(mem_rdata_i),
    .wf_free_i(wf_free_i), .wf_push_o(wf_push_o), .wf_data_o(wf_data_o), .busy_o(busy_o),
    .done_o(done_o), .stall_cycles_o(stall_cycles_o)
  );

  always #5 clk = ~clk;

  int     n_cmp = 0;
  int     n_bad = 0;
  longint cyc = 0;

  // knobs driven by the stimulus process
  int cap = 32;
  int drain_mode = 1;
  bit hold = 1'b0;
  int hold_pushes = 0;

  // reference model state
  logic [ADDR_W-1:0] addr_q[$];
  logic [RW-1:0]     data_q[$];
  int     issues_left = 0;
  int     inflight_m = 0;
  int     occ = 0;
  int     stall_m = 0;
  bit     run_active = 1'b0;
  bit     prev_rst = 1'b0;
  longint acc_cyc = 0;
  longint done_due = -1;
  bit                pv[MEM_LAT];
  logic [ADDR_W-1:0] pa[MEM_LAT];
  int                free_nxt = 0;
  logic [RW-1:0]     rdata_nxt = '0;

  function automatic logic [RW-1:0] row_of(input logic [ADDR_W-1:0] a);
    logic [RW-1:0] r;
    for (int w = 0; w < RW / 32; w++) r[w*32 +: 32] = {a, ~a} ^ (32'(w) * 32'h0100_0193);
    return r;
  endfunction

  function automatic logic [31:0] exp_stall();
`ifdef WFU_PERF_CNT_EN
    return 32'(stall_m);
`else
    return 32'd0;
`endif
  endfunction

  task automatic check(input string nm, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Monitor / scoreboard: samples mid-cycle, then models memory and FIFO for the next cycle.
  always @(negedge clk) begin
    logic [RW-1:0]     exp_row;
    logic [ADDR_W-1:0] a;
    bit                exp_done, exp_busy, exp_rd;
    int                tiles;
    cyc++;
    if (rst_i) begin
      addr_q.delete();
      data_q.delete();
      issues_left = 0;
      inflight_m  = 0;
      run_active  = 1'b0;
      done_due    = -1;
      stall_m     = 0;
      prev_rst    = 1'b1;
    end else begin
      if (prev_rst) begin
        check("reset_ctrl", {mem_rd_o, mem_addr_o, wf_push_o, busy_o, done_o, stall_cycles_o}, '0);
        check("reset_data", wf_data_o, '0);
      end
      prev_rst = 1'b0;
      check("push_timing", wf_push_o, pv[MEM_LAT-1]);
      exp_rd = (issues_left > 0) && (int'(wf_free_i) > inflight_m);
      check("issue_rule", mem_rd_o, exp_rd);
      if (issues_left > 0 && !mem_rd_o) stall_m++;
      if (mem_rd_o) begin
        if (addr_q.size() == 0) check("extra_read", mem_rd_o, 1'b0);
        else begin
          a = addr_q.pop_front();
          check("read_addr", mem_addr_o, a);
          issues_left--;
        end
        inflight_m++;
      end
      if (wf_push_o) begin
        check("fifo_space", occ < DEPTH, 1'b1);
        if (data_q.size() == 0) check("extra_push", wf_push_o, 1'b0);
        else begin
          exp_row = data_q.pop_front();
          check("push_data", wf_data_o, exp_row);
        end
        inflight_m--;
        if (hold) hold_pushes++;
        if (run_active && issues_left == 0 && inflight_m == 0) done_due = cyc + 1;
      end
      exp_done = (cyc == done_due);
      exp_busy = run_active && (cyc > acc_cyc) && !exp_done;
      check("done", done_o, exp_done);
      check("busy", busy_o, exp_busy);
      if (exp_done) begin
        check("stall_at_done", stall_cycles_o, exp_stall());
        run_active = 1'b0;
        done_due   = -1;
      end
      if (start_i && !run_active && !exp_done) begin
        check("stall_hold", stall_cycles_o, exp_stall());
        stall_m = 0;
        tiles = ((int'(u_dim_i) >> 5) * (int'(iter_dim_i) >> 5)) % 1024;
        for (int k = 0; k < tiles * MUL_SIZE; k++) begin
          a = base_addr_i + ADDR_W'(k);
          addr_q.push_back(a);
          data_q.push_back(row_of(a));
        end
        issues_left = tiles * MUL_SIZE;
        run_active  = 1'b1;
        acc_cyc     = cyc;
        if (tiles == 0) done_due = cyc + 2;
      end
    end
    if (wf_push_o) occ++;
    if (occ > 0 && (drain_mode == 1 || (drain_mode == 2 && $urandom_range(0, 3) != 0))) occ--;
    free_nxt = (cap > occ) ? cap - occ : 0;
    for (int j = MEM_LAT - 1; j > 0; j--) begin
      pv[j] = pv[j-1];
      pa[j] = pa[j-1];
    end
    pv[0] = mem_rd_o;
    pa[0] = mem_addr_o;
    if (rst_i) for (int j = 0; j < MEM_LAT; j++) pv[j] = 1'b0;
    rdata_nxt = pv[MEM_LAT-1] ? row_of(pa[MEM_LAT-1]) : {8{$urandom}};
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      wf_free_i   = (FIFO_AW + 1)'(free_nxt);
      mem_rdata_i = rdata_nxt;
    end
  end

  task automatic issue_start(input int u, input int it, input int b);
    @(posedge clk);
    #1;
    start_i     = 1'b1;
    u_dim_i     = 16'(u);
    iter_dim_i  = 16'(it);
    base_addr_i = ADDR_W'(b);
    @(posedge clk);
    #1;
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (k < budget && done_o !== 1'b1) begin
      @(negedge clk);
      k++;
    end
    if (done_o !== 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout: no done_o within %0d cycles", budget);
    end
  endtask

  task automatic run_cmd(input int u, input int it, input int b);
    issue_start(u, it, b);
    $display("cmd u=%0d iter=%0d base=%0h", u, it, b);
    wait_done(6000);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;

    run_cmd(64, 32, 'h100);
    run_cmd(16, 64, 'h200);

    cap = 3; drain_mode = 0; hold_pushes = 0; hold = 1'b1;
    issue_start(32, 64, 'h40);
    repeat (20) @(posedge clk);
    #1;
    check("hold_pushes", hold_pushes <= 3, 1'b1);
    hold = 1'b0; cap = 32; drain_mode = 1;
    wait_done(6000);

    issue_start(64, 64, 'h300);
    repeat (10) @(posedge clk);
    #1 rst_i = 1'b1;
    @(posedge clk);
    #1 rst_i = 1'b0;
    run_cmd(32, 32, 'h300);

    run_cmd(32, 32, 'hFFF0);

    issue_start(64, 32, 'h500);
    repeat (5) @(posedge clk);
    issue_start(96, 96, 'h700);
    wait_done(6000);

    drain_mode = 2;
    for (int r = 0; r < 8; r++) begin
      cap = $urandom_range(1, 32);
      run_cmd($urandom_range(0, 3) * 32 + $urandom_range(0, 31),
              $urandom_range(0, 2) * 32 + $urandom_range(0, 31), $urandom);
    end
    cap = 32; drain_mode = 1;

    repeat (5) @(negedge clk);
    check("queues_empty", addr_q.size() + data_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
